// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode bundle for the IF/ID buffer: the fetch word, hazard controls
// and the assembled decode-side instruction bundle.
interface if_id_buffer_if;
  logic [15:0] instr_in;
  logic [15:0] pc_in;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic [15:0] pc_out;
  logic        two_word;
  logic        out_valid;
  logic        imm_pending;

  modport master (
    output instr_in, pc_in, in_valid, stall, flush,
    input  instr_out, imm_out, pc_out, two_word, out_valid, imm_pending
  );

  modport slave (
    input  instr_in, pc_in, in_valid, stall, flush,
    output instr_out, imm_out, pc_out, two_word, out_valid, imm_pending
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register that joins opcode+immediate word pairs into one
// decode bundle, honouring hazard stalls and jump flushes.
module if_id_buffer #(
  parameter int          IMM_BIT  = 15,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  if_id_buffer_if.slave bus
);

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [15:0] hold_pc_q, hold_pc_d;
  logic [15:0] instr_out_q, instr_out_d;
  logic [15:0] imm_out_q, imm_out_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        two_word_q, two_word_d;
  logic        out_valid_q, out_valid_d;
  logic        imm_pending_q, imm_pending_d;

  always_comb begin
    // NOTE: every _d starts as its _q so unassigned paths hold state instead of inferring latches.
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_out_d  = instr_out_q;
    imm_out_d    = imm_out_q;
    pc_out_d     = pc_out_q;
    two_word_d   = two_word_q;
    out_valid_d  = out_valid_q;

    if (bus.flush) begin
      // Hold registers are left alone; they are rewritten before next use.
      state_d     = S_OP;
      out_valid_d = 1'b0;
      instr_out_d = NOP_WORD;
      two_word_d  = 1'b0;
      imm_out_d   = 16'h0000;
    end else if (bus.stall) begin
      // Fetch holds its PC on the same stall, so nothing needs capturing.
    end else if (!bus.in_valid) begin
      out_valid_d = 1'b0;
      instr_out_d = NOP_WORD;
    end else begin
      unique case (state_q)
        S_OP: begin
          if (bus.instr_in[IMM_BIT]) begin
            hold_instr_d = bus.instr_in;
            hold_pc_d    = bus.pc_in;
            out_valid_d  = 1'b0;
            instr_out_d  = NOP_WORD;
            state_d      = S_IMM;
          end else begin
            instr_out_d = bus.instr_in;
            pc_out_d    = bus.pc_in;
            imm_out_d   = 16'h0000;
            two_word_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
        S_IMM: begin
          // The immediate word is raw data; its IMM_BIT is not interpreted.
          instr_out_d = hold_instr_q;
          pc_out_d    = hold_pc_q;
          imm_out_d   = bus.instr_in;
          two_word_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end

    imm_pending_d = (state_d == S_IMM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_OP;
      hold_instr_q  <= 16'h0000;
      hold_pc_q     <= 16'h0000;
      instr_out_q   <= NOP_WORD;
      imm_out_q     <= 16'h0000;
      pc_out_q      <= 16'h0000;
      two_word_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      imm_pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      instr_out_q   <= instr_out_d;
      imm_out_q     <= imm_out_d;
      pc_out_q      <= pc_out_d;
      two_word_q    <= two_word_d;
      out_valid_q   <= out_valid_d;
      imm_pending_q <= imm_pending_d;
    end
  end

  assign bus.instr_out   = instr_out_q;
  assign bus.imm_out     = imm_out_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.two_word    = two_word_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.imm_pending = imm_pending_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: one task per scenario, with expected
// bundles written out by hand.
module tb_if_id_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  if_id_buffer_if bus ();

  if_id_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Full bundle {out_valid, two_word, imm_pending, instr_out, pc_out, imm_out}.
  function automatic logic [50:0] full_obs();
    return {bus.out_valid, bus.two_word, bus.imm_pending, bus.instr_out, bus.pc_out, bus.imm_out};
  endfunction

  task automatic drive(input logic v, input logic [15:0] w, input logic [15:0] pc);
    bus.in_valid = v;
    bus.instr_in = w;
    bus.pc_in    = pc;
  endtask

  // Advance one clock; observe 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [50:0] got;
    drive(1'b0, 16'h0000, 16'h0000);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rst = 1'b0;
    step();
    step();
    got = full_obs();
    checks++;
    if (got !== 51'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, 51'd0);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_one_word();
    logic [50:0] got;
    logic [16:0] sub;
    drive(1'b1, 16'h1234, 16'h0000);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL one_word_a: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000});
    end
    drive(1'b1, 16'h2345, 16'h0001);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 16'h2345, 16'h0001, 16'h0000}) begin
      errors++;
      $display("FAIL one_word_b: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 16'h2345, 16'h0001, 16'h0000});
    end
    drive(1'b0, 16'h7777, 16'h0002);
    step();
    sub = {bus.out_valid, bus.instr_out};
    checks++;
    if (sub !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL bubble_nop: got %h expected %h", sub, {1'b0, 16'h0000});
    end
  endtask

  task automatic test_two_word();
    logic [50:0] got;
    logic [17:0] sub;
    drive(1'b1, 16'h8001, 16'h0004);
    step();
    sub = {bus.out_valid, bus.imm_pending, bus.instr_out};
    checks++;
    if (sub !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL two_word_wait: got %h expected %h", sub, {1'b0, 1'b1, 16'h0000});
    end
    drive(1'b1, 16'hBEEF, 16'h0005);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 16'h8001, 16'h0004, 16'hBEEF}) begin
      errors++;
      $display("FAIL two_word_bundle: got %h expected %h", got, {1'b1, 1'b1, 1'b0, 16'h8001, 16'h0004, 16'hBEEF});
    end
  endtask

  task automatic test_bubble_gap();
    logic [50:0] got;
    logic [17:0] sub;
    drive(1'b1, 16'h8001, 16'h0008);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'hDEAD, 16'h00FF);
      step();
      sub = {bus.out_valid, bus.imm_pending, bus.instr_out};
      checks++;
      if (sub !== {1'b0, 1'b1, 16'h0000}) begin
        errors++;
        $display("FAIL gap_hold_%0d: got %h expected %h", i, sub, {1'b0, 1'b1, 16'h0000});
      end
    end
    drive(1'b1, 16'h00AA, 16'h0009);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 16'h8001, 16'h0008, 16'h00AA}) begin
      errors++;
      $display("FAIL gap_bundle: got %h expected %h", got, {1'b1, 1'b1, 1'b0, 16'h8001, 16'h0008, 16'h00AA});
    end
  endtask

  task automatic test_stall();
    logic [50:0] got;
    drive(1'b1, 16'h1234, 16'h0010);
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h5555 + 16'(i), 16'h0099);
      step();
      got = full_obs();
      checks++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'h1234, 16'h0010, 16'h0000}) begin
        errors++;
        $display("FAIL stall_freeze_%0d: got %h expected %h", i, got, {1'b1, 1'b0, 1'b0, 16'h1234, 16'h0010, 16'h0000});
      end
    end
    bus.stall = 1'b0;
    drive(1'b1, 16'h2345, 16'h0011);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 16'h2345, 16'h0011, 16'h0000}) begin
      errors++;
      $display("FAIL stall_resume: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 16'h2345, 16'h0011, 16'h0000});
    end
    // A stall while an opcode is held must not consume the immediate slot.
    drive(1'b1, 16'h8002, 16'h0020);
    step();
    bus.stall = 1'b1;
    drive(1'b1, 16'h7777, 16'h0077);
    step();
    checks++;
    if (bus.imm_pending !== 1'b1) begin
      errors++;
      $display("FAIL stall_in_imm: got %b expected %b", bus.imm_pending, 1'b1);
    end
    bus.stall = 1'b0;
    drive(1'b1, 16'hCAFE, 16'h0021);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 16'h8002, 16'h0020, 16'hCAFE}) begin
      errors++;
      $display("FAIL stall_imm_bundle: got %h expected %h", got, {1'b1, 1'b1, 1'b0, 16'h8002, 16'h0020, 16'hCAFE});
    end
  endtask

  task automatic test_flush();
    logic [50:0] got;
    logic [34:0] sub;
    drive(1'b1, 16'h8001, 16'h0030);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 16'hBEEF, 16'h0031);
    step();
    sub = {bus.out_valid, bus.two_word, bus.imm_pending, bus.instr_out, bus.imm_out};
    checks++;
    if (sub !== {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL flush_clear: got %h expected %h", sub, {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000});
    end
    bus.flush = 1'b0;
    drive(1'b1, 16'h1111, 16'h0032);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 16'h1111, 16'h0032, 16'h0000}) begin
      errors++;
      $display("FAIL flush_resume: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 16'h1111, 16'h0032, 16'h0000});
    end
  endtask

  task automatic test_flush_over_stall();
    logic [17:0] sub;
    drive(1'b1, 16'h1234, 16'h0038);
    step();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    drive(1'b1, 16'h2222, 16'h0039);
    step();
    sub = {bus.out_valid, bus.two_word, bus.instr_out};
    checks++;
    if (sub !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL flush_over_stall: got %h expected %h", sub, {1'b0, 1'b0, 16'h0000});
    end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [50:0] got;
    logic [17:0] sub;
    drive(1'b1, 16'h0F0F, 16'h0039);
    step();
    drive(1'b1, 16'h8001, 16'h0040);
    step();
    #2;
    rst = 1'b0;
    #1;
    got = full_obs();
    checks++;
    if (got !== 51'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", got, 51'd0);
    end
    rst = 1'b1;
    drive(1'b1, 16'hBEEF, 16'h0050);
    step();
    sub = {bus.out_valid, bus.imm_pending, bus.instr_out};
    checks++;
    if (sub !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL post_reset_opcode: got %h expected %h", sub, {1'b0, 1'b1, 16'h0000});
    end
    drive(1'b1, 16'h0001, 16'h0051);
    step();
    got = full_obs();
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0050, 16'h0001}) begin
      errors++;
      $display("FAIL post_reset_bundle: got %h expected %h", got, {1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0050, 16'h0001});
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_two_word();
    test_bubble_gap();
    test_stall();
    test_flush();
    test_flush_over_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Pipeline register and instruction assembler between the fetch stage and the decode stage.
- Accepts one 16-bit word per cycle from fetch, tagged with the PC of that word.
- Joins two-word instructions (opcode word followed by a 16-bit immediate word) into one decode-ready bundle.
- Applies hazard-unit stalls and jump flushes, so decode only ever sees complete, valid instructions or NOP bubbles.

Parameters:
- IMM_BIT, 15: bit position in the opcode word; 1 means the next fetched word is this instruction's immediate.
- NOP_WORD, 16'h0000: value driven on instr_out during a bubble or after a flush.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_in  in  16  word from the fetch stage (instruction or immediate).
- pc_in  in  16  PC of instr_in.
- in_valid  in  1  instr_in/pc_in are meaningful this cycle.
- stall  in  1  hazard unit hold; freezes this stage.
- flush  in  1  jump taken (conditional or direct); discards in-flight contents.
- instr_out  out  16  opcode word to decode.
- imm_out  out  16  immediate word; 0 for one-word instructions.
- pc_out  out  16  PC of the opcode word.
- two_word  out  1  imm_out is valid (two-word instruction).
- out_valid  out  1  bundle on the outputs is a real instruction.
- imm_pending  out  1  high while in S_IMM (for debug and hazard visibility).

Behaviour:
- Two states: S_OP (expecting an opcode word) and S_IMM (holding an opcode word, expecting its immediate).
- Internal hold registers: hold_instr[15:0] and hold_pc[15:0].
- Reset (rst=0, asynchronous): state=S_OP; instr_out=NOP_WORD; imm_out=0; pc_out=0; two_word=0; out_valid=0; hold registers=0; imm_pending=0.
  - Reset released mid two-word assembly: the held word is lost; the stage restarts in S_OP.
- Priority per clock edge: flush > stall > normal operation.
- flush=1:
  - out_valid<=0, instr_out<=NOP_WORD, two_word<=0, imm_out<=0; state<=S_OP.
  - The instr_in presented in the same cycle is discarded, even if in_valid=1.
  - hold registers are not cleared (don't-care after flush).
- stall=1 and flush=0: state, hold registers and all outputs keep their values; instr_in is ignored. Fetch holds its PC on the same stall, so no word is lost.
- Normal operation, in_valid=0: out_valid<=0, instr_out<=NOP_WORD; state and hold registers unchanged. A bubble may separate an opcode word from its immediate.
- Normal operation, S_OP, in_valid=1, instr_in[IMM_BIT]=0:
  - instr_out<=instr_in, pc_out<=pc_in, imm_out<=0, two_word<=0, out_valid<=1.
  - Latency: 1 cycle from input to output.
- Normal operation, S_OP, in_valid=1, instr_in[IMM_BIT]=1:
  - hold_instr<=instr_in, hold_pc<=pc_in; out_valid<=0, instr_out<=NOP_WORD; state<=S_IMM.
- Normal operation, S_IMM, in_valid=1:
  - instr_out<=hold_instr, pc_out<=hold_pc, imm_out<=instr_in, two_word<=1, out_valid<=1; state<=S_OP.
  - IMM_BIT of the immediate word is not interpreted.
- imm_pending is a registered copy of (state==S_IMM).
- Throughput: one one-word instruction per cycle; one two-word instruction per two valid input cycles.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then in_valid=1 with words 16'h1234 @pc 0, then 16'h2345 @pc 1 -> out_valid=1 with instr_out=1234/pc_out=0, then instr_out=2345/pc_out=1 on consecutive cycles; two_word=0, imm_out=0.
2. Word 16'h8001 @pc 4 followed by 16'hBEEF @pc 5 -> one cycle with out_valid=0 and imm_pending=1, then instr_out=8001, imm_out=BEEF, pc_out=4, two_word=1, out_valid=1.
3. Word 16'h8001, then in_valid=0 for 2 cycles, then 16'h00AA -> bubbles with imm_pending=1 held during the gap, then bundle 8001/00AA.
4. Stall asserted for 3 cycles while outputs show 16'h1234 -> outputs frozen for all 3 cycles; inputs presented during the stall are ignored; 16'h2345 applied after stall deasserts appears next.
5. Word 16'h8001 (state S_IMM), then flush=1 together with 16'hBEEF -> out_valid=0, instr_out=0000, state S_OP; next word 16'h1111 is output as a one-word instruction.
6. flush and stall both high -> flush wins (out_valid=0). Drive rst=0 asynchronously mid-cycle while in S_IMM -> all outputs 0 immediately; after release, 16'hBEEF is treated as an opcode word (bit15=1 -> enters S_IMM).
